uart_tx_byte: RTL and testbench
===============================

Name: uart_tx_byte

Overview:
- Serial transmit stage directly downstream of the button/value storage block.
- Accepts one 8-bit value with a one-cycle trigger pulse and shifts it out on a UART line as 8N1, LSB first.
- Returns a one-cycle ready pulse when the line is idle again; the storage block uses that pulse to release its output-wait state.
- Also drives a busy level and a sticky overrun flag for board LEDs/debug.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- io_output_value  input  8  byte to send; sampled only in the cycle a trigger is accepted.
- io_output_trigger  input  1  send request, nominally a one-cycle pulse.
- io_output_ready_trigger  output  1  one-cycle pulse when a frame (including stop bits) has completed.
- tx  output  1  UART line, idle high; registered output.
- busy  output  1  high from the cycle after acceptance until the ready pulse cycle, inclusive.
- overrun  output  1  sticky; set when a trigger arrives while busy.

Behaviour:
- Reset values: tx=1, busy=0, io_output_ready_trigger=0, overrun=0, state=IDLE, bit counter=0, clock divider=0.
- Reset is synchronous and takes priority over every other input, including mid-frame. tx returns high the cycle after reset is sampled; no ready pulse is issued for an aborted frame.

States:
- IDLE
  - tx=1.
  - If io_output_trigger is sampled high at edge T: latch io_output_value into the shift register and go to START.
- START
  - tx=0 for exactly CLKS_PER_BIT cycles, covering cycles T+1 .. T+CLKS_PER_BIT.
- DATA
  - 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Bit index counter is 3 bits; leave DATA when the index is 7 and the divider is terminal.
- PARITY
  - Entered only when the optional feature is compiled in; see Optional Feature.
- STOP
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- DONE
  - One cycle: io_output_ready_trigger=1, busy=1, tx=1.
  - Next state is IDLE.

Timing:
- Without parity, the frame occupies cycles T+1 .. T+(9+STOP_BITS)*CLKS_PER_BIT.
- The ready pulse is asserted in cycle T+(9+STOP_BITS)*CLKS_PER_BIT+1.
- A trigger sampled in the DONE cycle is ignored and sets overrun. The earliest accepted back-to-back trigger is the cycle after DONE.

Clock divider:
- Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Width is $clog2(CLKS_PER_BIT), minimum 1.
- Held at 0 in IDLE.

Trigger handling:
- io_output_value may change freely after acceptance; the latched copy is transmitted.
- A trigger held high for multiple cycles starts exactly one frame; the extra cycles fall into START/busy and set overrun.
- Trigger while busy (START..DONE): ignored, overrun<=1, frame in flight unaffected.
- overrun clears only on reset.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0).
  - After DATA, a PARITY state drives one bit for CLKS_PER_BIT cycles: the XOR of the latched byte, inverted when PARITY_ODD=1.
  - Frame length becomes (10+STOP_BITS)*CLKS_PER_BIT and ready shifts one bit time later.
- Undefined: no PARITY state, no PARITY_ODD parameter; frame is 8N1/8N2.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1 unless stated):
- Reset, then trigger with 0xA5 at cycle T:
  - tx reads 1 before T+1.
  - T+1..T+4 = 0.
  - Data bits 1,0,1,0,0,1,0,1 for 4 cycles each over T+5..T+36.
  - Stop bit 1 over T+37..T+40.
  - Ready pulse at T+41 only; busy high T+1..T+41.
- Back-to-back: send 0x00, then trigger 0xFF the cycle after ready:
  - Second start bit begins on the following cycle.
  - Exactly two ready pulses in total; overrun stays 0.
- Trigger 0x3C during the data phase of frame 0x81:
  - Line carries only 0x81's bits.
  - One ready pulse; overrun=1 and stays 1 until reset.
- Trigger held high for 3 cycles with 0x55, changing the value to 0x00 on the second cycle:
  - One frame transmitting 0x55; overrun=1.
- Reset asserted mid-frame, at data bit 3 of 0xF0:
  - tx=1 on the next cycle; no ready pulse; busy=0.
  - A new trigger with 0x0F after reset transmits correctly.
- With UART_TX_PARITY_EN defined and PARITY_ODD=0:
  - Sending 0x07 gives parity bit 1 at T+37..T+40 and a ready pulse at T+45.
  - With STOP_BITS=2 and no parity, ready arrives at T+45.

Source files
------------

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: byte-wide UART transmitter (8N1/8N2, LSB first) with ready pulse, busy and sticky overrun.
// Optional parity bit when UART_TX_PARITY_EN is defined (adds parameter PARITY_ODD).
// Ports:
//   clk                     system clock, posedge
//   reset                   synchronous active-high reset
//   io_output_value[7:0]    byte to send, latched when a trigger is accepted
//   io_output_trigger       send request
//   io_output_ready_trigger one-cycle pulse after the last stop bit
//   tx                      registered UART line, idle high
//   busy                    high from the cycle after acceptance through the ready pulse
//   overrun                 sticky, set by a trigger while busy, cleared by reset
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] io_output_value,
    input  logic       io_output_trigger,
    output logic       io_output_ready_trigger,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);
    localparam int DW = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;
    state_t state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] data_q, data_d;
    logic tx_q, tx_d, busy_q, busy_d, rdy_q, rdy_d, ovr_q, ovr_d;
    logic term;
    assign term = div_q == DW'(CLKS_PER_BIT - 1);
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rdy_d   = 1'b0;
        ovr_d   = ovr_q | (io_output_trigger && state_q != IDLE);
        div_d   = (state_q == IDLE || state_q == DONE || term) ? '0 : div_q + 1'b1;
        case (state_q)
            IDLE: if (io_output_trigger) begin
                data_d  = io_output_value;
                state_d = START;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                bit_d   = '0;
            end
            START: if (term) begin
                state_d = DATA;
                tx_d    = data_q[0];
            end
            DATA: if (term) begin
                // bit index wraps 7 -> 0, which also seeds the stop-bit count
                bit_d = bit_q + 3'd1;
                tx_d  = data_q[bit_q + 3'd1];
                if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = ^data_q ^ PARITY_ODD;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (term) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (term) begin
                if (bit_q == 3'(STOP_BITS - 1)) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                bit_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
        end
    end
    assign tx                      = tx_q;
    assign busy                    = busy_q;
    assign io_output_ready_trigger = rdy_q;
    assign overrun                 = ovr_q;
endmodule

// File: tb/tb_uart_tx_byte.sv
// tb_uart_tx_byte: checks uart_tx_byte (1 and 2 stop bits) against a frame-level reference model.
module tb_uart_tx_byte;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    logic clk = 1'b0, reset = 1'b1, trig = 1'b0;
    logic [7:0] val = 8'h00;
    logic tx1, busy1, rdy1, ovr1, tx2, busy2, rdy2, ovr2;
    int total = 0, bad = 0, rdy_cnt = 0;
    always #5 clk = ~clk;
    uart_tx_byte #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .io_output_value(val), .io_output_trigger(trig),
        .io_output_ready_trigger(rdy1), .tx(tx1), .busy(busy1), .overrun(ovr1));
    uart_tx_byte #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .io_output_value(val), .io_output_trigger(trig),
        .io_output_ready_trigger(rdy2), .tx(tx2), .busy(busy2), .overrun(ovr2));
    // reference model: k = cycles since the accepting edge, frame = list of bit slots of C cycles
    bit m_act[2];
    int m_k[2];
    logic [7:0] m_b[2];
    bit m_ovr[2];
    function automatic int flen(int i);
        return (9 + (i + 1) + P) * C;
    endfunction
    function automatic logic exp_tx(int i);
        int b;
        if (!m_act[i]) return 1'b1;
        b = (m_k[i] - 1) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_b[i][b-1];
        if (P == 1 && b == 9) return ^m_b[i];
        return 1'b1;
    endfunction
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] <= 1'b0;
                m_ovr[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (trig) m_ovr[i] <= 1'b1;
                if (m_k[i] == flen(i) + 1) m_act[i] <= 1'b0;
                else m_k[i] <= m_k[i] + 1;
            end else if (trig) begin
                m_act[i] <= 1'b1;
                m_k[i]   <= 1;
                m_b[i]   <= val;
            end
        end
    end
    task automatic cmp(string n, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, got, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        cmp("tx1", tx1, exp_tx(0));
        cmp("busy1", busy1, m_act[0]);
        cmp("rdy1", rdy1, m_act[0] && m_k[0] == flen(0) + 1);
        cmp("ovr1", ovr1, m_ovr[0]);
        cmp("tx2", tx2, exp_tx(1));
        cmp("busy2", busy2, m_act[1]);
        cmp("rdy2", rdy2, m_act[1] && m_k[1] == flen(1) + 1);
        cmp("ovr2", ovr2, m_ovr[1]);
        if (rdy1) rdy_cnt <= rdy_cnt + 1;
    end
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    // Starts a frame from the current negedge and returns at the negedge of the ready cycle.
    task automatic run_frame(input logic [7:0] v, input int hold, input int inj,
                             output logic [7:0] got, output int lat);
        bit seen = 0;
        got = 'x;
        lat = -1;
        trig = 1'b1;
        val = v;
        for (int j = 1; j <= 200 && !seen; j++) begin
            @(negedge clk);
            if (j == 1) begin
                val = 8'h00;
                cmp("start_tx", tx1, 1'b0);
                cmp("start_busy", busy1, 1'b1);
            end
            if (j == hold) trig = 1'b0;
            if (j == inj) begin trig = 1'b1; val = 8'h3C; end
            if (inj != 0 && j == inj + 1) trig = 1'b0;
            if (j > C && j <= 9 * C && (j - C - 1) % C == C / 2) got[(j-C-1)/C] = tx1;
            if (rdy1) begin seen = 1; lat = j; end
        end
        trig = 1'b0;
        if (!seen) cmp("frame_timeout", 0, 1);
    endtask
    typedef struct {
        logic [7:0] v;
        int hold;
        int inj;
        logic [7:0] exp_byte;
        logic exp_ovr;
    } vec_t;
    vec_t tbl[6];
    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
    initial begin
        logic [7:0] got;
        int lat, rc0;
        logic [50:1] o_tx, o_r1, o_b, o_r2, e_tx, e_r1, e_b, e_r2;
        int abits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        tbl[0] = '{8'h00, 1, 0, 8'h00, 1'b0};
        tbl[1] = '{8'hFF, 1, 0, 8'hFF, 1'b0};
        tbl[2] = '{8'h5A, 2, 0, 8'h5A, 1'b1};
        tbl[3] = '{8'hC3, 1, 20, 8'hC3, 1'b1};
        tbl[4] = '{8'h01, 1, 0, 8'h01, 1'b0};
        tbl[5] = '{8'h80, 3, 0, 8'h80, 1'b1};
        tick(3);
        cmp("reset_tx", tx1, 1'b1);
        cmp("reset_busy", busy1, 1'b0);
        cmp("reset_rdy", rdy1, 1'b0);
        cmp("reset_ovr", ovr1, 1'b0);
        reset = 1'b0;
        tick(2);
        // 0xA5 waveform against the literal frame
        cmp("idle_tx", tx1, 1'b1);
        trig = 1'b1;
        val = 8'hA5;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            trig = 1'b0;
            val = 8'h00;
            o_tx[j] = tx1; o_r1[j] = rdy1; o_b[j] = busy1; o_r2[j] = rdy2;
            e_tx[j] = (j <= C) ? 1'b0 : (j <= 9 * C) ? 1'(abits[(j-C-1)/C])
                    : (P == 1 && j <= 10 * C) ? 1'b0 : 1'b1;
            e_r1[j] = j == 41 + 4 * P;
            e_b[j]  = j <= 41 + 4 * P;
            e_r2[j] = j == 45 + 4 * P;
        end
        cmp("a5_tx", o_tx, e_tx);
        cmp("a5_rdy", o_r1, e_r1);
        cmp("a5_busy", o_b, e_b);
        cmp("a5_rdy_2stop", o_r2, e_r2);
        // back-to-back
        rc0 = rdy_cnt;
        run_frame(8'h00, 1, 0, got, lat);
        cmp("b2b_first", got, 8'h00);
        @(negedge clk);
        run_frame(8'hFF, 1, 0, got, lat);
        cmp("b2b_second", got, 8'hFF);
        tick(3);
        cmp("b2b_ready_count", rdy_cnt - rc0, 2);
        cmp("b2b_ovr", ovr1, 1'b0);
        // trigger during data of 0x81
        rc0 = rdy_cnt;
        run_frame(8'h81, 1, 14, got, lat);
        cmp("inj_byte", got, 8'h81);
        cmp("inj_ovr", ovr1, 1'b1);
        tick(30);
        cmp("inj_ready_count", rdy_cnt - rc0, 1);
        cmp("inj_ovr_sticky", ovr1, 1'b1);
        cmp("inj_idle", busy1, 1'b0);
        // trigger held three cycles, value changes on the second
        pulse_reset();
        tick(10);
        run_frame(8'h55, 3, 0, got, lat);
        cmp("hold_byte", got, 8'h55);
        cmp("hold_ovr", ovr1, 1'b1);
        // reset at data bit 3 of 0xF0
        pulse_reset();
        tick(10);
        rc0 = rdy_cnt;
        trig = 1'b1;
        val = 8'hF0;
        for (int j = 1; j <= 4 * C + 2; j++) begin
            @(negedge clk);
            trig = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("abort_tx", tx1, 1'b1);
        cmp("abort_busy", busy1, 1'b0);
        cmp("abort_rdy", rdy1, 1'b0);
        tick(60);
        cmp("abort_no_ready", rdy_cnt - rc0, 0);
        run_frame(8'h0F, 1, 0, got, lat);
        cmp("abort_next_byte", got, 8'h0F);
        // table-driven frames
        foreach (tbl[i]) begin
            tick(10);
            pulse_reset();
            tick(2);
            run_frame(tbl[i].v, tbl[i].hold, tbl[i].inj, got, lat);
            cmp($sformatf("tbl%0d_byte", i), got, tbl[i].exp_byte);
            cmp($sformatf("tbl%0d_lat", i), lat, 41 + 4 * P);
            cmp($sformatf("tbl%0d_ovr", i), ovr1, tbl[i].exp_ovr);
        end
        // random traffic, the model checks every cycle
        for (int n = 0; n < 200; n++) begin
            logic [7:0] v;
            int inj;
            v = 8'($urandom);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0;
            tick(int'($urandom_range(1, 50)));
            if ($urandom_range(0, 19) == 0) pulse_reset();
            run_frame(v, int'($urandom_range(1, 3)), inj, got, lat);
            cmp("rnd_byte", got, v);
            cmp("rnd_lat", lat, 41 + 4 * P);
        end
        tick(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
